dma_reader: RTL and testbench

- Bus-master DMA engine for the memory-to-local-buffer direction; a companion to the existing DMA writer.
- Under CPU control it fetches 16-bit samples from system memory with a programmable address stride and writes them sequentially into a local sink buffer (e.g. an output/coefficient RAM), one block per xfer_block request.
- Sits on the CPU data bus as a peripheral and on the DMA bus as a master.

---
 rtl/dma_reader.sv | 257 +++++++++++++++++++++++++
 tb/tb_dma_reader.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_reader.sv
// dma_reader: bus-master DMA that copies strided 16-bit samples from system memory into a local sink buffer.
// Optional interrupt output and IRQ_EN register (index 7) are enabled by defining DMA_READER_IRQ_EN.
module dma_reader #(
    parameter int unsigned ADDR  = 0,
    parameter int unsigned WIDTH = 8
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic        wb_dbus_cyc,
    input  logic        wb_dbus_we,
    input  logic [31:0] wb_dbus_adr,
    input  logic [31:0] wb_dbus_dat,
    output logic [31:0] dbus_rdt,
    output logic        dbus_ack,
    input  logic        xfer_block,
    output logic        block_done,
    output logic        xfer_done,
    output logic [15:0] xfer_adr,
    output logic        xfer_we,
    output logic [15:0] xfer_dat,
    output logic        dma_cyc,
    output logic        dma_we,
    output logic [3:0]  dma_sel,
    output logic [31:0] dma_adr,
    input  logic [31:0] dma_rdt,
`ifdef DMA_READER_IRQ_EN
    output logic        irq,
`endif
    input  logic        dma_ack
);

    localparam logic [WIDTH-1:0] CS_MATCH = ADDR[WIDTH-1:0];

    typedef enum logic [2:0] {IDLE, ARMED, FETCH, STORE, DONE} state_t;

    state_t      state, next_state;

    logic [23:0] cfg_addr;
    logic [15:0] cfg_step;
    logic [15:0] cfg_count;
    logic [15:0] cfg_blocks;
`ifdef DMA_READER_IRQ_EN
    logic [1:0]  irq_en;
`endif

    logic [23:0] run_addr;
    logic [15:0] run_blocks;
    logic [23:0] addr;
    logic [23:0] addr_next;
    logic [15:0] step;
    logic [15:0] cnt;
    logic        stop_pending;
    logic        busy;

    logic [2:0]  reg_idx;
    logic        cs_hit;
    logic        reg_wr;
    logic        start_req;
    logic        stop_req;
    logic        abort;
    logic        last_block;
    logic        block_start;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign reg_idx     = wb_dbus_adr[4:2];
    assign cs_hit      = wb_dbus_cyc && (wb_dbus_adr[31 -: WIDTH] == CS_MATCH);
    assign reg_wr      = dbus_ack && wb_dbus_we;
    assign start_req   = reg_wr && (reg_idx == 3'd4);
    assign stop_req    = reg_wr && (reg_idx == 3'd5);
    assign abort       = stop_req || stop_pending;
    assign last_block  = (run_blocks == 16'd1);
    assign block_start = (state == ARMED) && xfer_block && !stop_req;
    assign addr_next   = addr + {8'h00, step};
    assign dma_we      = 1'b0;
    assign unused_bits = ^{wb_dbus_adr[23:5], wb_dbus_adr[1:0], wb_dbus_dat[31:24]};

    // Single-cycle ack; the bus holds address/data through the ack cycle, so writes commit then.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            dbus_ack <= 1'b0;
        end else begin
            dbus_ack <= cs_hit && !dbus_ack;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cfg_addr   <= '0;
            cfg_step   <= '0;
            cfg_count  <= '0;
            cfg_blocks <= '0;
`ifdef DMA_READER_IRQ_EN
            irq_en     <= '0;
`endif
        end else if (reg_wr) begin
            case (reg_idx)
                3'd0: cfg_addr   <= wb_dbus_dat[23:0];
                3'd1: cfg_step   <= wb_dbus_dat[15:0];
                3'd2: cfg_count  <= wb_dbus_dat[15:0];
                3'd3: cfg_blocks <= wb_dbus_dat[15:0];
`ifdef DMA_READER_IRQ_EN
                3'd7: irq_en     <= wb_dbus_dat[1:0];
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            3'd0: rd_data = {8'h00, cfg_addr};
            3'd1: rd_data = {16'h0000, cfg_step};
            3'd2: rd_data = {16'h0000, cfg_count};
            3'd3: rd_data = {16'h0000, cfg_blocks};
            3'd6: rd_data = {29'h0, busy, block_done, xfer_done};
`ifdef DMA_READER_IRQ_EN
            3'd7: rd_data = {30'h0, irq_en};
`endif
            default: rd_data = '0;
        endcase
    end

    assign dbus_rdt = (dbus_ack && !wb_dbus_we) ? rd_data : 32'h0;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A STOP during FETCH is remembered so the outstanding bus cycle can finish before returning to IDLE.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start_req) next_state = (cfg_blocks == 16'd0) ? DONE : ARMED;
            end
            ARMED: begin
                if (stop_req) begin
                    next_state = IDLE;
                end else if (xfer_block) begin
                    if (cfg_count == 16'd0) next_state = last_block ? DONE : ARMED;
                    else                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (dma_ack) next_state = abort ? IDLE : STORE;
            end
            STORE: begin
                if (stop_req)           next_state = IDLE;
                else if (cnt == 16'd1)  next_state = last_block ? DONE : ARMED;
                else                    next_state = FETCH;
            end
            DONE: begin
                if (stop_req) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        dma_cyc = 1'b0;
        dma_sel = 4'b0000;
        dma_adr = 32'h0;
        xfer_we = 1'b0;
        busy    = 1'b0;
        case (state)
            FETCH: begin
                dma_cyc = 1'b1;
                dma_sel = addr[1] ? 4'b1100 : 4'b0011;
                dma_adr = {8'h00, addr[23:2], 2'b00};
                busy    = 1'b1;
            end
            STORE: begin
                xfer_we = 1'b1;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    // Flags are only ever nonzero outside IDLE, so clearing them on every IDLE entry covers all STOP paths.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            run_addr     <= '0;
            run_blocks   <= '0;
            addr         <= '0;
            step         <= '0;
            cnt          <= '0;
            xfer_adr     <= '0;
            xfer_dat     <= '0;
            block_done   <= 1'b0;
            xfer_done    <= 1'b0;
            stop_pending <= 1'b0;
        end else begin
            stop_pending <= (state == FETCH) && !dma_ack && abort;
            case (state)
                IDLE: begin
                    if (start_req) begin
                        run_addr   <= cfg_addr;
                        run_blocks <= cfg_blocks;
                        xfer_done  <= (cfg_blocks == 16'd0);
                    end
                end
                ARMED: begin
                    if (block_start) begin
                        step       <= cfg_step;
                        cnt        <= cfg_count;
                        addr       <= run_addr;
                        xfer_adr   <= '0;
                        block_done <= (cfg_count == 16'd0);
                        if (cfg_count == 16'd0) begin
                            run_blocks <= run_blocks - 16'd1;
                            xfer_done  <= last_block;
                        end
                    end
                end
                FETCH: begin
                    if (dma_ack && !abort) xfer_dat <= addr[1] ? dma_rdt[31:16] : dma_rdt[15:0];
                end
                STORE: begin
                    xfer_adr <= xfer_adr + 16'd1;
                    addr     <= addr_next;
                    cnt      <= cnt - 16'd1;
                    if (cnt == 16'd1) begin
                        block_done <= 1'b1;
                        run_addr   <= addr_next;
                        run_blocks <= run_blocks - 16'd1;
                        xfer_done  <= last_block;
                    end
                end
                default: ;
            endcase
            if (next_state == IDLE) begin
                block_done <= 1'b0;
                xfer_done  <= 1'b0;
            end
        end
    end

`ifdef DMA_READER_IRQ_EN
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            irq <= 1'b0;
        end else if (next_state == IDLE || block_start) begin
            irq <= 1'b0;
        end else begin
            irq <= (block_done & irq_en[1]) | (xfer_done & irq_en[0]);
        end
    end
`endif

endmodule

// File: tb/tb_dma_reader.sv
// tb_dma_reader: register table, directed multi-cycle sequences and randomized transfers for dma_reader,
// checked against a queue-based reference model of the expected bus beats and sink writes.
module tb_dma_reader;

    logic        wb_clk;
    logic        wb_rst_n;
    logic        wb_dbus_cyc;
    logic        wb_dbus_we;
    logic [31:0] wb_dbus_adr;
    logic [31:0] wb_dbus_dat;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic        xfer_block;
    logic        block_done;
    logic        xfer_done;
    logic [15:0] xfer_adr;
    logic        xfer_we;
    logic [15:0] xfer_dat;
    logic        dma_cyc;
    logic        dma_we;
    logic [3:0]  dma_sel;
    logic [31:0] dma_adr;
    logic [31:0] dma_rdt;
    logic        dma_ack;
`ifdef DMA_READER_IRQ_EN
    logic        irq;
`endif

    dma_reader dut (
        .wb_clk      (wb_clk),
        .wb_rst_n    (wb_rst_n),
        .wb_dbus_cyc (wb_dbus_cyc),
        .wb_dbus_we  (wb_dbus_we),
        .wb_dbus_adr (wb_dbus_adr),
        .wb_dbus_dat (wb_dbus_dat),
        .dbus_rdt    (dbus_rdt),
        .dbus_ack    (dbus_ack),
        .xfer_block  (xfer_block),
        .block_done  (block_done),
        .xfer_done   (xfer_done),
        .xfer_adr    (xfer_adr),
        .xfer_we     (xfer_we),
        .xfer_dat    (xfer_dat),
        .dma_cyc     (dma_cyc),
        .dma_we      (dma_we),
        .dma_sel     (dma_sel),
        .dma_adr     (dma_adr),
        .dma_rdt     (dma_rdt),
`ifdef DMA_READER_IRQ_EN
        .irq         (irq),
`endif
        .dma_ack     (dma_ack)
    );

`ifdef DMA_READER_IRQ_EN
    localparam logic [31:0] REG7_EXP = 32'h3;
`else
    localparam logic [31:0] REG7_EXP = 32'h0;
`endif

    typedef struct packed {
        logic [31:0] adr;
        logic [3:0]  sel;
    } beat_t;

    typedef struct {
        bit          do_write;
        logic [2:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp_read;
    } reg_vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [512];
    beat_t       beat_q[$];
    logic [31:0] wr_q[$];
    int          ack_fixed = -1;
    int          max_delay = 0;
    int          wait_cnt  = -1;

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory slave: acks each request once after a fixed or random number of wait cycles.
    initial begin
        dma_ack = 1'b0;
        dma_rdt = 32'h0;
        forever begin
            @(posedge wb_clk);
            #1;
            if (dma_ack) begin
                dma_ack  = 1'b0;
                dma_rdt  = 32'h0;
                wait_cnt = -1;
            end else if (dma_cyc) begin
                if (wait_cnt < 0) wait_cnt = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, max_delay));
                if (wait_cnt == 0) begin
                    dma_ack  = 1'b1;
                    dma_rdt  = mem[dma_adr[10:2]];
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end else begin
                wait_cnt = -1;
            end
        end
    end

    always @(negedge wb_clk) begin
        if (dma_cyc && dma_ack) beat_q.push_back('{adr: dma_adr, sel: dma_sel});
        if (xfer_we) wr_q.push_back({xfer_adr, xfer_dat});
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cpu_access(input bit we, input logic [2:0] idx, input logic [31:0] wdata,
                              output logic [31:0] rdata);
        int n;
        wb_dbus_cyc = 1'b1;
        wb_dbus_we  = we;
        wb_dbus_adr = {8'h00, 19'h0, idx, 2'b00};
        wb_dbus_dat = wdata;
        n = 0;
        do begin
            @(posedge wb_clk);
            #1;
            n++;
        end while (!dbus_ack && n < 8);
        checkOutput("busAck", {63'h0, dbus_ack}, 64'h1);
        rdata       = dbus_rdt;
        wb_dbus_cyc = 1'b0;
        @(posedge wb_clk);
        #1;
        wb_dbus_we  = 1'b0;
    endtask

    task automatic cpu_write(input logic [2:0] idx, input logic [31:0] wdata);
        logic [31:0] dummy;
        cpu_access(1'b1, idx, wdata, dummy);
    endtask

    task automatic cpu_read(input logic [2:0] idx, output logic [31:0] rdata);
        cpu_access(1'b0, idx, 32'h0, rdata);
    endtask

    task automatic pulse_block();
        xfer_block = 1'b1;
        @(posedge wb_clk);
        #1;
        xfer_block = 1'b0;
    endtask

    function automatic logic [15:0] mem_half(input logic [23:0] a);
        logic [31:0] w;
        w = mem[a[10:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Runs a complete transfer and compares every bus beat and sink write with the arithmetic model.
    task automatic applyStimulus(input logic [23:0] base, input logic [15:0] stp, input logic [15:0] count,
                                 input logic [15:0] blocks, input bit noisy);
        logic [31:0] rd;
        logic [23:0] a;
        int          n;
        int          k;
        beat_q.delete();
        wr_q.delete();
        cpu_write(3'd0, {8'h00, base});
        cpu_write(3'd1, {16'h0, stp});
        cpu_write(3'd2, {16'h0, count});
        cpu_write(3'd3, {16'h0, blocks});
        cpu_write(3'd4, 32'h0);
        for (int b = 0; b < int'(blocks); b++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge wb_clk);
                #1;
            end
            pulse_block();
            n = 0;
            while (!block_done && n < 300) begin
                xfer_block = noisy && dma_cyc && ($urandom_range(0, 2) == 0);
                @(posedge wb_clk);
                #1;
                xfer_block = 1'b0;
                n++;
            end
            checkOutput("blockDoneSeen", {63'h0, block_done}, 64'h1);
            checkOutput("xferDoneTiming", {63'h0, xfer_done}, {63'h0, (b == int'(blocks) - 1)});
        end
        cpu_read(3'd6, rd);
        checkOutput("statusDone", rd, 32'h3);
        checkOutput("beatCount", beat_q.size(), int'(blocks) * int'(count));
        checkOutput("writeCount", wr_q.size(), int'(blocks) * int'(count));
        k = 0;
        for (int b = 0; b < int'(blocks); b++) begin
            for (int i = 0; i < int'(count); i++) begin
                a = base + 24'((b * int'(count) + i) * int'(stp));
                if (k < beat_q.size())
                    checkOutput("beat", beat_q[k], {8'h00, a[23:2], 2'b00, (a[1] ? 4'b1100 : 4'b0011)});
                if (k < wr_q.size())
                    checkOutput("sinkWrite", wr_q[k], {16'(i), mem_half(a)});
                k++;
            end
        end
        cpu_write(3'd5, 32'h0);
        cpu_read(3'd6, rd);
        checkOutput("statusAfterStop", rd, 32'h0);
    endtask

    initial begin
        reg_vec_t    reg_vecs[8];
        logic [31:0] rd;
        logic [3:0]  ack_pat;
        bit          held;
        int          n;

        reg_vecs[0] = '{1'b1, 3'd0, 32'hFFAB_CDEF, 32'h00AB_CDEF};
        reg_vecs[1] = '{1'b1, 3'd1, 32'h1234_5678, 32'h0000_5678};
        reg_vecs[2] = '{1'b1, 3'd2, 32'hFFFF_0003, 32'h0000_0003};
        reg_vecs[3] = '{1'b1, 3'd3, 32'h0001_0002, 32'h0000_0002};
        reg_vecs[4] = '{1'b0, 3'd4, 32'h0,         32'h0};
        reg_vecs[5] = '{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0};
        reg_vecs[6] = '{1'b0, 3'd6, 32'h0,         32'h0};
        reg_vecs[7] = '{1'b1, 3'd7, 32'hFFFF_FFFF, REG7_EXP};

        wb_rst_n    = 1'b0;
        wb_dbus_cyc = 1'b0;
        wb_dbus_we  = 1'b0;
        wb_dbus_adr = 32'h0;
        wb_dbus_dat = 32'h0;
        xfer_block  = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = $urandom;

        repeat (3) @(posedge wb_clk);
        #1;
        checkOutput("resetCtrl", {dma_cyc, dma_we, dma_sel, xfer_we, block_done, xfer_done, dbus_ack}, 64'h0);
        checkOutput("resetData", {dma_adr, xfer_adr, xfer_dat}, 64'h0);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        @(posedge wb_clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            if (reg_vecs[i].do_write) cpu_write(reg_vecs[i].idx, reg_vecs[i].wdata);
            cpu_read(reg_vecs[i].idx, rd);
            checkOutput($sformatf("regRead%0d", reg_vecs[i].idx), rd, reg_vecs[i].exp_read);
        end

        // Holding cyc must give isolated one-cycle acks.
        wb_dbus_cyc = 1'b1;
        wb_dbus_we  = 1'b0;
        wb_dbus_adr = {8'h00, 19'h0, 3'd3, 2'b00};
        for (int i = 3; i >= 0; i--) begin
            @(posedge wb_clk);
            #1;
            ack_pat[i] = dbus_ack;
        end
        wb_dbus_cyc = 1'b0;
        @(posedge wb_clk);
        #1;
        checkOutput("ackPattern", {60'h0, ack_pat}, 64'hA);

        mem[9'h040] = 32'h5A5A_1111;
        mem[9'h041] = 32'h6B6B_2222;
        mem[9'h042] = 32'h7C7C_3333;
        applyStimulus(24'h000100, 16'd4, 16'd3, 16'd1, 1'b0);
        checkOutput("t1Beat0", (beat_q.size() > 0) ? beat_q[0] : 36'h0, {32'h0000_0100, 4'b0011});
        checkOutput("t1Write2", (wr_q.size() > 2) ? wr_q[2] : 32'hFFFF_FFFF, {16'd2, 16'h3333});

        mem[9'h040] = 32'hAAAA_BBBB;
        mem[9'h041] = 32'hCCCC_DDDD;
        applyStimulus(24'h000102, 16'd2, 16'd2, 16'd2, 1'b0);
        checkOutput("t2Beat0", (beat_q.size() > 0) ? beat_q[0] : 36'h0, {32'h0000_0100, 4'b1100});
        checkOutput("t2Write1", (wr_q.size() > 1) ? wr_q[1] : 32'hFFFF_FFFF, {16'd1, 16'hDDDD});
        checkOutput("t2Beat2", (beat_q.size() > 2) ? beat_q[2] : 36'h0, {32'h0000_0104, 4'b1100});
        checkOutput("t2Write2", (wr_q.size() > 2) ? wr_q[2] : 32'hFFFF_FFFF, {16'd0, 16'hCCCC});

        max_delay = 5;
        for (int it = 0; it < 10; it++) begin
            applyStimulus(24'($urandom_range(0, 1023)), 16'($urandom_range(0, 16)),
                          16'($urandom_range(1, 5)), 16'($urandom_range(1, 3)), 1'b1);
        end
        max_delay = 0;

        // STOP while a fetch is stalled: the cycle must complete without a sink write.
        ack_fixed = 4;
        cpu_write(3'd0, 32'h200);
        cpu_write(3'd1, 32'h4);
        cpu_write(3'd2, 32'h2);
        cpu_write(3'd3, 32'h1);
        cpu_write(3'd4, 32'h0);
        beat_q.delete();
        wr_q.delete();
        pulse_block();
        n = 0;
        while (!dma_cyc && n < 10) begin
            @(posedge wb_clk);
            #1;
            n++;
        end
        checkOutput("stopFetchStarted", {63'h0, dma_cyc}, 64'h1);
        cpu_write(3'd5, 32'h0);
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge wb_clk);
            #1;
            if (beat_q.size() == 0 && !dma_cyc) held = 1'b0;
        end
        checkOutput("stopCycHeld", {63'h0, held}, 64'h1);
        checkOutput("stopBeats", beat_q.size(), 64'd1);
        checkOutput("stopNoWrite", wr_q.size(), 64'd0);
        checkOutput("stopCycLow", {63'h0, dma_cyc}, 64'h0);
        cpu_read(3'd6, rd);
        checkOutput("stopStatus", rd, 32'h0);

        ack_fixed = -1;
        cpu_write(3'd3, 32'h0);
        cpu_write(3'd4, 32'h0);
        checkOutput("zeroBlocksDone", {62'h0, block_done, xfer_done}, 64'h1);
        cpu_write(3'd5, 32'h0);

        // COUNT of zero completes the block without any bus traffic.
`ifdef DMA_READER_IRQ_EN
        cpu_write(3'd7, 32'h1);
`endif
        cpu_write(3'd0, 32'h300);
        cpu_write(3'd2, 32'h0);
        cpu_write(3'd3, 32'h1);
        cpu_write(3'd4, 32'h0);
        beat_q.delete();
        pulse_block();
        checkOutput("countZeroFlags", {62'h0, block_done, xfer_done}, 64'h3);
`ifdef DMA_READER_IRQ_EN
        checkOutput("irqNotYet", {63'h0, irq}, 64'h0);
        @(posedge wb_clk);
        #1;
        checkOutput("irqRise", {63'h0, irq}, 64'h1);
`endif
        repeat (3) @(posedge wb_clk);
        #1;
        checkOutput("countZeroNoBeat", beat_q.size(), 64'd0);
        cpu_read(3'd6, rd);
        checkOutput("countZeroStatus", rd, 32'h3);
        cpu_write(3'd5, 32'h0);

        // Asynchronous reset in the middle of a stalled fetch.
        ack_fixed = 10;
        cpu_write(3'd0, 32'h300);
        cpu_write(3'd1, 32'h4);
        cpu_write(3'd2, 32'h4);
        cpu_write(3'd3, 32'h1);
        cpu_write(3'd4, 32'h0);
        pulse_block();
        n = 0;
        while (!dma_cyc && n < 10) begin
            @(posedge wb_clk);
            #1;
            n++;
        end
        checkOutput("rstFetchStarted", {63'h0, dma_cyc}, 64'h1);
        @(posedge wb_clk);
        #3;
        wb_rst_n = 1'b0;
        #1;
        checkOutput("rstCtrl", {dma_cyc, dma_we, dma_sel, xfer_we, block_done, xfer_done, dbus_ack}, 64'h0);
        checkOutput("rstData", {dma_adr, xfer_adr, xfer_dat}, 64'h0);
        @(negedge wb_clk);
        wb_rst_n  = 1'b1;
        ack_fixed = -1;
        @(posedge wb_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            cpu_read(3'(i), rd);
            checkOutput($sformatf("rstReg%0d", i), rd, 32'h0);
        end
        cpu_read(3'd6, rd);
        checkOutput("rstStatus", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
